sd_req_arbiter: RTL

//   Multi-channel block-request sequencer between emulated storage controllers (HDD, floppy

---
 rtl/sd_req_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_req_arbiter.sv
// Block-request sequencer between emulated storage controllers and the hps_io virtual-disk port.
// Latches per-channel requests, grants round-robin, runs the strobe/ack handshake with a watchdog.
module sd_req_arbiter #(
    parameter int unsigned       NUM_CH  = 3,
    parameter int unsigned       TO_W    = 24,
    parameter logic [TO_W-1:0]   TIMEOUT = TO_W'(24'hFFFFFF)
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [NUM_CH-1:0]      req_rd,
    input  logic [NUM_CH-1:0]      req_wr,
    input  logic [32*NUM_CH-1:0]   req_lba,
    input  logic [NUM_CH-1:0]      mounted,
    output logic [32*NUM_CH-1:0]   sd_lba,
    output logic [NUM_CH-1:0]      sd_rd,
    output logic [NUM_CH-1:0]      sd_wr,
    input  logic [NUM_CH-1:0]      sd_ack,
    output logic [NUM_CH-1:0]      cpu_wait,
    output logic [NUM_CH-1:0]      done,
    output logic [NUM_CH-1:0]      err
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IX_W = CH_W + 1;
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);
    localparam bit TO_EN = (TIMEOUT != '0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic [1:0]          state,    state_nx;
    logic [CH_W-1:0]     grant,    grant_nx;
    logic [CH_W-1:0]     rr,       rr_nx;
    logic                is_wr,    is_wr_nx;
    logic                repend,   repend_nx;
    logic [TO_W-1:0]     timer,    timer_nx;
    logic [NUM_CH-1:0]   pend_rd,  pend_rd_nx;
    logic [NUM_CH-1:0]   pend_wr,  pend_wr_nx;
    logic [NUM_CH-1:0]   ack_q;
    logic [31:0]         lba_q     [NUM_CH];
    logic [31:0]         lba_q_nx  [NUM_CH];
    logic [31:0]         sd_lba_q  [NUM_CH];
    logic [31:0]         sd_lba_nx [NUM_CH];
    logic [NUM_CH-1:0]   sd_rd_nx, sd_wr_nx, done_nx, err_nx, cpu_wait_nx;
    logic                clr;
    logic                arb_hit;
    logic [CH_W-1:0]     arb_ch;

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        logic [IX_W-1:0] idx;
        idx     = '0;
        arb_hit = 1'b0;
        arb_ch  = '0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            idx = IX_W'(rr) + IX_W'(k);
            if (idx >= IX_W'(NUM_CH)) begin
                idx = idx - IX_W'(NUM_CH);
            end
            if (pend_rd[idx[CH_W-1:0]] | pend_wr[idx[CH_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_ch  = idx[CH_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        rr_nx      = rr;
        is_wr_nx   = is_wr;
        repend_nx  = repend;
        timer_nx   = timer;
        pend_rd_nx = pend_rd;
        pend_wr_nx = pend_wr;
        lba_q_nx   = lba_q;
        sd_lba_nx  = sd_lba_q;
        sd_rd_nx   = sd_rd;
        sd_wr_nx   = sd_wr;
        done_nx    = '0;
        err_nx     = '0;
        clr        = 1'b0;

        case (state)
            S_IDLE: begin
                if (arb_hit) begin
                    grant_nx            = arb_ch;
                    is_wr_nx            = pend_wr[arb_ch];
                    sd_lba_nx[arb_ch]   = lba_q[arb_ch];
                    if (pend_wr[arb_ch]) begin
                        sd_wr_nx[arb_ch] = 1'b1;
                    end else begin
                        sd_rd_nx[arb_ch] = 1'b1;
                    end
                    timer_nx  = '0;
                    repend_nx = 1'b0;
                    state_nx  = S_REQ;
                end
            end
            S_REQ: begin
                timer_nx = timer + TO_W'(1);
                if (sd_ack[grant] & ~ack_q[grant]) begin
                    sd_rd_nx = '0;
                    sd_wr_nx = '0;
                    clr      = 1'b1;
                    state_nx = S_XFER;
                end else if (TO_EN && (timer == TO_LAST)) begin
                    sd_rd_nx       = '0;
                    sd_wr_nx       = '0;
                    clr            = 1'b1;
                    err_nx[grant]  = 1'b1;
                    state_nx       = S_IDLE;
                end
            end
            S_XFER: begin
                if (!sd_ack[grant]) begin
                    done_nx[grant] = 1'b1;
                    rr_nx    = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                sd_rd_nx = '0;
                sd_wr_nx = '0;
            end
        endcase

        // A same-direction pulse on the granted channel while the strobe is up stays pending.
        if (state == S_REQ && !clr) begin
            if (is_wr ? req_wr[grant] : req_rd[grant]) begin
                repend_nx = 1'b1;
            end
        end
        if (mounted[grant]) begin
            repend_nx = 1'b0;
        end

        if (clr) begin
            if (is_wr) begin
                pend_wr_nx[grant] = repend;
            end else begin
                pend_rd_nx[grant] = repend;
            end
        end

        pend_rd_nx = pend_rd_nx | req_rd;
        pend_wr_nx = pend_wr_nx | req_wr;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (req_rd[i] | req_wr[i]) begin
                lba_q_nx[i] = req_lba[32*i +: 32];
            end
        end
        pend_rd_nx = pend_rd_nx & ~mounted;
        pend_wr_nx = pend_wr_nx & ~mounted;

        cpu_wait_nx = pend_rd_nx | pend_wr_nx;
        if (state_nx != S_IDLE) begin
            cpu_wait_nx = cpu_wait_nx | (NUM_CH'(1) << grant_nx);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            grant    <= '0;
            rr       <= '0;
            is_wr    <= 1'b0;
            repend   <= 1'b0;
            timer    <= '0;
            pend_rd  <= '0;
            pend_wr  <= '0;
            ack_q    <= '0;
            sd_rd    <= '0;
            sd_wr    <= '0;
            done     <= '0;
            err      <= '0;
            cpu_wait <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                lba_q[i]    <= '0;
                sd_lba_q[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            rr       <= rr_nx;
            is_wr    <= is_wr_nx;
            repend   <= repend_nx;
            timer    <= timer_nx;
            pend_rd  <= pend_rd_nx;
            pend_wr  <= pend_wr_nx;
            ack_q    <= sd_ack;
            sd_rd    <= sd_rd_nx;
            sd_wr    <= sd_wr_nx;
            done     <= done_nx;
            err      <= err_nx;
            cpu_wait <= cpu_wait_nx;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                lba_q[i]    <= lba_q_nx[i];
                sd_lba_q[i] <= sd_lba_nx[i];
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_lba
        assign sd_lba[32*g +: 32] = sd_lba_q[g];
    end

endmodule
